// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: write/read handshake and status bundle of sync_fifo_flags.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_cs;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_cs;
  logic                  rd_en;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  modport master (
    output wr_cs, wr_en, data_in, rd_cs, rd_en, clr_err,
    input  data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  wr_cs, wr_en, data_in, rd_cs, rd_en, clr_err,
    output data_out, data_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock circular FIFO with registered or FWFT read,
// programmable almost flags and sticky overflow/underflow.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              reset,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_full;
  logic                  w_empty;
  always_comb begin
    w_wr_req = bus.wr_cs & bus.wr_en;
    w_rd_req = bus.rd_cs & bus.rd_en;
    w_full   = r_count == (ADDR_WIDTH+1)'(DEPTH);
    w_empty  = r_count == '0;
    w_rd_acc = w_rd_req & !w_empty;
    // a full FIFO still takes a write when the same cycle frees a slot
    w_wr_acc = w_wr_req & (!w_full | w_rd_acc);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc != w_rd_acc) r_count <= w_wr_acc ? r_count + 1'b1 : r_count - 1'b1;
      if (w_rd_acc) r_data <= r_mem[r_rd_ptr];
      r_valid <= w_rd_acc;
      r_ovf   <= (w_wr_req & !w_wr_acc) | (r_ovf & !bus.clr_err);
      r_udf   <= (w_rd_req & w_empty) | (r_udf & !bus.clr_err);
    end
  always_ff @(posedge clk)
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.data_in;
  always_comb begin
    bus.data_out     = FWFT != 0 ? (w_empty ? '0 : r_mem[r_rd_ptr]) : r_data;
    bus.data_valid   = FWFT != 0 ? !w_empty : r_valid;
    bus.full         = w_full;
    bus.empty        = w_empty;
    bus.almost_full  = r_count >= (ADDR_WIDTH+1)'(AF_LEVEL);
    bus.almost_empty = r_count <= (ADDR_WIDTH+1)'(AE_LEVEL);
    bus.count        = r_count;
    bus.overflow     = r_ovf;
    bus.underflow    = r_udf;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed vector table plus corner-case sequences for
// a registered-read instance (u_a) and an FWFT instance (u_b).
module tb_sync_fifo_flags;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ia ();
  sync_fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) ib ();
  sync_fifo_flags #(.FWFT(0)) u_a (.clk(clk), .reset(reset), .bus(ia));
  sync_fifo_flags #(.FWFT(1)) u_b (.clk(clk), .reset(reset), .bus(ib));
  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       rd;
    logic       clr;
    int         cnt;
    logic [7:0] dout;
    logic       vld;
    logic       ovf;
    logic       udf;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic wr, logic [7:0] d, logic rd, logic clr, int cnt,
                              logic [7:0] dout, logic vld, logic ovf, logic udf);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.clr = clr; v.cnt = cnt;
    v.dout = dout; v.vld = vld; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_a(input string tag, input int cnt, input logic [7:0] dout, input logic vld,
                       input logic ovf, input logic udf);
    chk({tag, " count"}, 32'(ia.count), cnt);
    chk({tag, " full"}, 32'(ia.full), 32'(cnt == 8));
    chk({tag, " empty"}, 32'(ia.empty), 32'(cnt == 0));
    chk({tag, " almost_full"}, 32'(ia.almost_full), 32'(cnt >= 6));
    chk({tag, " almost_empty"}, 32'(ia.almost_empty), 32'(cnt <= 1));
    chk({tag, " data_valid"}, 32'(ia.data_valid), 32'(vld));
    chk({tag, " data_out"}, 32'(ia.data_out), 32'(dout));
    chk({tag, " overflow"}, 32'(ia.overflow), 32'(ovf));
    chk({tag, " underflow"}, 32'(ia.underflow), 32'(udf));
  endtask
  task automatic chk_b(input string tag, input int cnt, input logic [7:0] dout, input logic vld);
    chk({tag, " count"}, 32'(ib.count), cnt);
    chk({tag, " empty"}, 32'(ib.empty), 32'(cnt == 0));
    chk({tag, " data_valid"}, 32'(ib.data_valid), 32'(vld));
    chk({tag, " data_out"}, 32'(ib.data_out), 32'(dout));
  endtask
  task automatic idle();
    {ia.wr_cs, ia.wr_en, ia.rd_cs, ia.rd_en, ia.clr_err} = '0;
    {ib.wr_cs, ib.wr_en, ib.rd_cs, ib.rd_en, ib.clr_err} = '0;
    ia.data_in = '0;
    ib.data_in = '0;
  endtask
  task automatic cyc(input bit sel, input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    @(negedge clk);
    if (!sel) begin
      ia.wr_cs = wr; ia.wr_en = wr; ia.data_in = d; ia.rd_cs = rd; ia.rd_en = rd; ia.clr_err = clr;
    end else begin
      ib.wr_cs = wr; ib.wr_en = wr; ib.data_in = d; ib.rd_cs = rd; ib.rd_en = rd; ib.clr_err = clr;
    end
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_b("fwft reset", 0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 8'(8'h10 + k - 1), 0, 0, k, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 0, 8, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8, 8'h00, 0, 0, 0));
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(0, 8'h00, 1, 0, 8 - k, 8'(8'h10 + k - 1), 1, 0, 0));
    tbl.push_back(mk(1, 8'h33, 1, 0, 1, 8'h17, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 8'h33, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 8'h33, 0, 0, 0));
    foreach (tbl[i]) begin
      cyc(0, tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].clr);
      chk_a($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].vld, tbl[i].ovf, tbl[i].udf);
    end
    // full FIFO with read+write every cycle: pointers wrap, occupancy pinned at 8
    for (int k = 0; k < 8; k++) cyc(0, 1, 8'(8'h20 + k), 0, 0);
    chk_a("refill", 8, 8'h33, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 8'h55, 1, 0);
      chk_a($sformatf("rw_full%0d", k), 8, k < 8 ? 8'(8'h20 + k) : 8'h55, 1, 0, 0);
    end
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 8'h00, 1, 0);
      chk_a($sformatf("drain%0d", k), 7 - k, 8'h55, 1, 0, 0);
    end
    cyc(0, 0, 8'h00, 1, 0);
    chk_a("udf_pre", 0, 8'h55, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 1, 8'(8'h40 + k), 0, 0);
    chk_a("burst5", 5, 8'h55, 0, 0, 1);
    @(negedge clk);
    ia.wr_cs = 1; ia.wr_en = 1; ia.data_in = 8'h77; ia.rd_cs = 1; ia.rd_en = 1;
    #2 reset = 1'b1;
    #1;
    chk_a("async_reset", 0, 8'h00, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_a("reset_hold", 0, 8'h00, 0, 0, 0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 8'h99, 0, 0);
    chk_a("post_wr", 1, 8'h00, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 0);
    chk_a("post_rd", 0, 8'h99, 1, 0, 0);
    chk_b("fwft idle", 0, 8'h00, 0);
    cyc(1, 1, 8'hC3, 0, 0);
    chk_b("fwft wr", 1, 8'hC3, 1);
    cyc(1, 0, 8'h00, 0, 0);
    chk_b("fwft hold", 1, 8'hC3, 1);
    cyc(1, 1, 8'hD4, 0, 0);
    chk_b("fwft wr2", 2, 8'hC3, 1);
    cyc(1, 0, 8'h00, 1, 0);
    chk_b("fwft pop1", 1, 8'hD4, 1);
    cyc(1, 0, 8'h00, 1, 0);
    chk_b("fwft pop2", 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 1, 0);
    chk("fwft underflow", 32'(ib.underflow), 1);
    chk("fwft no overflow", 32'(ib.overflow), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised single-clock circular FIFO; next generation of the team's 4-entry chip-select FIFO.
- Adds generic depth/width, a selectable output mode (registered vs first-word-fall-through) and programmable almost-full/almost-empty flags.
- Adds sticky overflow/underflow error flags and simultaneous read/write while full.
- Sits between producer/consumer stages in the datapath as the standard buffering primitive.

Parameters:
DATA_WIDTH, 8, data word width in bits
ADDR_WIDTH, 3, pointer width; DEPTH = 1<<ADDR_WIDTH entries (default 8)
AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (legal 1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (legal 0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
wr_cs  in  1  write chip select
wr_en  in  1  write enable
data_in  in  DATA_WIDTH  write data
rd_cs  in  1  read chip select
rd_en  in  1  read enable (FWFT=1: acknowledge/pop of head word)
clr_err  in  1  synchronous clear of overflow/underflow
data_out  out  DATA_WIDTH  read data
data_valid  out  1  data_out qualifier
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_WIDTH+1  current occupancy 0..DEPTH
overflow  out  1  sticky: write requested but rejected
underflow  out  1  sticky: read requested while empty

Behaviour:
- Request terms: wr_req = wr_cs & wr_en; rd_req = rd_cs & rd_en.
- Accepts: rd_acc = rd_req & !empty; wr_acc = wr_req & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- wr_acc: mem[wr_ptr] <= data_in; wr_ptr += 1, wraps DEPTH-1 -> 0. Memory is never written otherwise.
- rd_acc: rd_ptr += 1, wraps DEPTH-1 -> 0.
- count: +1 on wr_acc & !rd_acc; -1 on rd_acc & !wr_acc; unchanged when both or neither. Never exceeds DEPTH or goes below 0.
- full, empty, almost_full and almost_empty decode combinationally from the registered count; no extra latency.
- Reset (async, any time including mid-burst):
  - wr_ptr = rd_ptr = count = 0; data_out = 0; data_valid = 0; overflow = underflow = 0.
  - Outputs after reset: empty = 1, full = 0, almost_empty = 1 (AE_LEVEL >= 0), almost_full = 0.
  - Memory contents are not reset and are unobservable.
- FWFT=0 (registered read):
  - On rd_acc at edge N, data_out <= mem[rd_ptr] and data_valid = 1 during cycle N+1.
  - data_valid = 0 in any cycle following an edge without rd_acc; data_out holds its last value (never X).
  - Read latency 1 cycle. A word written at edge N is first readable by rd_acc at edge N+1.
- FWFT=1 (first-word-fall-through):
  - data_valid = !empty; data_out = mem[rd_ptr] when !empty, else 0.
  - A word written into an empty FIFO at edge N appears on data_out in cycle N+1 (1-cycle write-to-visible).
  - rd_acc pops the head; the next word, or 0 with data_valid = 0, shows after the edge.
- Errors:
  - overflow <= 1 when wr_req & !wr_acc.
  - underflow <= 1 when rd_req & empty.
  - Both are sticky until reset or clr_err; a set in the same cycle as clr_err wins.
  - A rejected request changes no pointer, count or memory.
- Simultaneous read+write when empty: only the write is accepted, count 0 -> 1, underflow sets.
- Simultaneous read+write when full: both are accepted, count stays at DEPTH, no overflow.

Test Plan:
- Reset, then write 8 words 0x10..0x17 (defaults, FWFT=0):
  - full = 1, count = 8, almost_full asserts when count reaches 6.
  - Read 8 words: data_out = 0x10..0x17, each 1 cycle after its read; empty = 1 at end; almost_empty high at count <= 1.
- Full FIFO, 9th write of 0xAA: rejected, overflow = 1, count = 8. clr_err clears overflow next cycle; contents unchanged.
- Full FIFO, simultaneous read+write of 0x55 repeated 12 cycles: count stays 8, no overflow, pointers wrap. Drain order is intact, with 0x55 as the last 8 words.
- Empty FIFO, simultaneous read+write of 0x33: count = 1, underflow = 1. Next read returns 0x33.
- FWFT=1: write 0xC3 into empty -> data_valid = 1, data_out = 0xC3 the next cycle with no read. Pop -> data_valid = 0, data_out = 0.
- Assert reset mid-burst at count = 5 with wr/rd active: all outputs return to reset values immediately. The first post-reset write/read round-trips correctly.
